dom_tree_builder: RTL and testbench

- Downstream consumer of the element tag parser.
- Turns its per-tag results (tag code, opening/closing flag, attribute k/v) into a stream of DOM node records: node id, parent id, depth.
- Keeps an open-element stack so that closing tags are matched to their opening tags.
- Output feeds the layout/render stage, which stores node and attribute records by node id.

---
 rtl/dom_tree_builder_if.sv | 58 +++++
 rtl/dom_tree_builder.sv | 194 +++++++++++++++++++
 tb/tb_dom_tree_builder.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dom_tree_builder_if.sv
// Parser-to-DOM-builder bundle: per-tag parser results in, node/close/attribute records out.
`ifndef DOM_TREE_DEFS
`define DOM_TREE_DEFS
`define ELE_TAG_BITES 5
`define ATTRIBUTE_TYPE_BITES 4
`define ATTRIBUTE_VAL_BITES 8
`define TAG_BODY 1
`define TAG_DIV 2
`define TAG_P 3
`define TAG_IMG 4
`define TAG_A 5
`endif

interface dom_tree_builder_if #(
  parameter int unsigned NODE_ID_BITS = 6,
  parameter int unsigned DEPTH_BITS   = 4
);
  // Parser side
  logic                              element_done;
  logic [`ELE_TAG_BITES-1:0]         element_tag;
  logic                              is_closing_tag;
  logic                              has_attribute;
  logic [`ATTRIBUTE_TYPE_BITES-1:0]  attribute_type;
  logic [`ATTRIBUTE_VAL_BITES-1:0]   attribute_value;
  // Builder side
  logic                              node_valid;
  logic [NODE_ID_BITS-1:0]           node_id;
  logic [NODE_ID_BITS-1:0]           node_parent_id;
  logic [`ELE_TAG_BITES-1:0]         node_tag;
  logic [DEPTH_BITS-1:0]             node_depth;
  logic                              close_valid;
  logic [NODE_ID_BITS-1:0]           close_id;
  logic                              attr_valid;
  logic [NODE_ID_BITS-1:0]           attr_node_id;
  logic [`ATTRIBUTE_TYPE_BITES-1:0]  attr_type;
  logic [`ATTRIBUTE_VAL_BITES-1:0]   attr_value;
  logic                              doc_done;
  logic                              err_overflow;
  logic                              err_underflow;
  logic                              err_mismatch;
  logic                              err_node_full;

  modport master (
    output element_done, element_tag, is_closing_tag, has_attribute, attribute_type,
           attribute_value,
    input  node_valid, node_id, node_parent_id, node_tag, node_depth, close_valid, close_id,
           attr_valid, attr_node_id, attr_type, attr_value, doc_done, err_overflow,
           err_underflow, err_mismatch, err_node_full
  );

  modport slave (
    input  element_done, element_tag, is_closing_tag, has_attribute, attribute_type,
           attribute_value,
    output node_valid, node_id, node_parent_id, node_tag, node_depth, close_valid, close_id,
           attr_valid, attr_node_id, attr_type, attr_value, doc_done, err_overflow,
           err_underflow, err_mismatch, err_node_full
  );
endinterface

// File: rtl/dom_tree_builder.sv
// Builds DOM node records from parser tag events using an open-element stack.
`ifndef DOM_TREE_DEFS
`define DOM_TREE_DEFS
`define ELE_TAG_BITES 5
`define ATTRIBUTE_TYPE_BITES 4
`define ATTRIBUTE_VAL_BITES 8
`define TAG_BODY 1
`define TAG_DIV 2
`define TAG_P 3
`define TAG_IMG 4
`define TAG_A 5
`endif

module dom_tree_builder #(
  parameter int unsigned MAX_DEPTH    = 8,
  parameter int unsigned DEPTH_BITS   = 4,
  parameter int unsigned NODE_ID_BITS = 6
) (
  input logic               clock,
  input logic               reset_n,
  dom_tree_builder_if.slave bus
);

  localparam int unsigned IdxBits = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam int unsigned TagBits = `ELE_TAG_BITES;
  localparam int unsigned AtBits  = `ATTRIBUTE_TYPE_BITES;
  localparam int unsigned AvBits  = `ATTRIBUTE_VAL_BITES;
  localparam logic [TagBits-1:0] TagBody = TagBits'(`TAG_BODY);
  localparam logic [TagBits-1:0] TagImg  = TagBits'(`TAG_IMG);

  typedef enum logic [1:0] {StIdle, StOpen, StClose} state_e;

  state_e                  state_q;
  logic                    done_q;
  logic                    attr_q;
  logic [TagBits-1:0]      tag_q;
  logic [DEPTH_BITS-1:0]   depth_q;
  logic [NODE_ID_BITS-1:0] next_id_q;
  logic [NODE_ID_BITS-1:0] stack_id_q  [MAX_DEPTH];
  logic [TagBits-1:0]      stack_tag_q [MAX_DEPTH];

  logic                    node_valid_q;
  logic [NODE_ID_BITS-1:0] node_id_q;
  logic [NODE_ID_BITS-1:0] node_parent_id_q;
  logic [TagBits-1:0]      node_tag_q;
  logic [DEPTH_BITS-1:0]   node_depth_q;
  logic                    close_valid_q;
  logic [NODE_ID_BITS-1:0] close_id_q;
  logic                    attr_valid_q;
  logic [NODE_ID_BITS-1:0] attr_node_id_q;
  logic [AtBits-1:0]       attr_type_q;
  logic [AvBits-1:0]       attr_value_q;
  logic                    doc_done_q;
  logic                    err_overflow_q;
  logic                    err_underflow_q;
  logic                    err_mismatch_q;
  logic                    err_node_full_q;

  logic                    done_rise;
  logic                    attr_rise;
  logic [IdxBits-1:0]      top_idx;
  logic [IdxBits-1:0]      push_idx;
  logic [NODE_ID_BITS-1:0] top_id;
  logic [TagBits-1:0]      top_tag;
  logic                    stack_empty;
  logic                    stack_full;
  logic                    ids_gone;

  // Rise detection and stack-top lookup.
  always_comb begin
    done_rise   = bus.element_done & ~done_q;
    attr_rise   = bus.has_attribute & ~attr_q;
    top_idx     = IdxBits'(depth_q - 1'b1);
    push_idx    = IdxBits'(depth_q);
    top_id      = stack_id_q[top_idx];
    top_tag     = stack_tag_q[top_idx];
    stack_empty = (depth_q == '0);
    stack_full  = (depth_q == DEPTH_BITS'(MAX_DEPTH));
    // next_id wraps to 0 after the last valid id; 0 therefore means "exhausted"
    ids_gone    = (next_id_q == '0);
  end

  // Control FSM, stack and all registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StIdle;
      done_q           <= 1'b0;
      attr_q           <= 1'b0;
      tag_q            <= '0;
      depth_q          <= '0;
      next_id_q        <= NODE_ID_BITS'(1);
      for (int i = 0; i < MAX_DEPTH; i++) begin
        stack_id_q[i]  <= '0;
        stack_tag_q[i] <= '0;
      end
      node_valid_q     <= 1'b0;
      node_id_q        <= '0;
      node_parent_id_q <= '0;
      node_tag_q       <= '0;
      node_depth_q     <= '0;
      close_valid_q    <= 1'b0;
      close_id_q       <= '0;
      attr_valid_q     <= 1'b0;
      attr_node_id_q   <= '0;
      attr_type_q      <= '0;
      attr_value_q     <= '0;
      doc_done_q       <= 1'b0;
      err_overflow_q   <= 1'b0;
      err_underflow_q  <= 1'b0;
      err_mismatch_q   <= 1'b0;
      err_node_full_q  <= 1'b0;
    end else begin
      done_q        <= bus.element_done;
      attr_q        <= bus.has_attribute;
      node_valid_q  <= 1'b0;
      close_valid_q <= 1'b0;
      attr_valid_q  <= 1'b0;

      // Attribute belongs to the element about to be opened, i.e. the current next_id.
      if (attr_rise && !bus.is_closing_tag && !ids_gone) begin
        attr_valid_q   <= 1'b1;
        attr_node_id_q <= next_id_q;
        attr_type_q    <= bus.attribute_type;
        attr_value_q   <= bus.attribute_value;
      end

      case (state_q)
        StIdle: begin
          if (done_rise) begin
            tag_q   <= bus.element_tag;
            state_q <= bus.is_closing_tag ? StClose : StOpen;
          end
        end
        StOpen: begin
          state_q <= StIdle;
          if (ids_gone) begin
            err_node_full_q <= 1'b1;
          end else if (stack_full) begin
            err_overflow_q <= 1'b1;
          end else begin
            node_valid_q     <= 1'b1;
            node_id_q        <= next_id_q;
            node_parent_id_q <= stack_empty ? '0 : top_id;
            node_tag_q       <= tag_q;
            node_depth_q     <= depth_q;
            next_id_q        <= next_id_q + 1'b1;
            // Void elements never get a closing tag, so they are not pushed.
            if (tag_q != TagImg) begin
              stack_id_q[push_idx]  <= next_id_q;
              stack_tag_q[push_idx] <= tag_q;
              depth_q               <= depth_q + 1'b1;
            end
          end
        end
        StClose: begin
          state_q <= StIdle;
          if (stack_empty) begin
            err_underflow_q <= 1'b1;
          end else begin
            // Pop even on mismatch so a stray close tag cannot wedge the stack.
            depth_q       <= depth_q - 1'b1;
            close_valid_q <= 1'b1;
            close_id_q    <= top_id;
            if (top_tag != tag_q) begin
              err_mismatch_q <= 1'b1;
            end
            if ((depth_q == DEPTH_BITS'(1)) && (top_tag == TagBody)) begin
              doc_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.node_valid     = node_valid_q;
  assign bus.node_id        = node_id_q;
  assign bus.node_parent_id = node_parent_id_q;
  assign bus.node_tag       = node_tag_q;
  assign bus.node_depth     = node_depth_q;
  assign bus.close_valid    = close_valid_q;
  assign bus.close_id       = close_id_q;
  assign bus.attr_valid     = attr_valid_q;
  assign bus.attr_node_id   = attr_node_id_q;
  assign bus.attr_type      = attr_type_q;
  assign bus.attr_value     = attr_value_q;
  assign bus.doc_done       = doc_done_q;
  assign bus.err_overflow   = err_overflow_q;
  assign bus.err_underflow  = err_underflow_q;
  assign bus.err_mismatch   = err_mismatch_q;
  assign bus.err_node_full  = err_node_full_q;

endmodule

// File: tb/tb_dom_tree_builder.sv
// Bench for dom_tree_builder: directed scenarios plus randomized tag streams vs a stack model.
`ifndef DOM_TREE_DEFS
`define DOM_TREE_DEFS
`define ELE_TAG_BITES 5
`define ATTRIBUTE_TYPE_BITES 4
`define ATTRIBUTE_VAL_BITES 8
`define TAG_BODY 1
`define TAG_DIV 2
`define TAG_P 3
`define TAG_IMG 4
`define TAG_A 5
`endif

module tb_dom_tree_builder;

  localparam int unsigned TW  = `ELE_TAG_BITES;
  localparam int unsigned ATW = `ATTRIBUTE_TYPE_BITES;
  localparam int unsigned AVW = `ATTRIBUTE_VAL_BITES;
  localparam logic [TW-1:0] TBODY = TW'(`TAG_BODY);
  localparam logic [TW-1:0] TDIV  = TW'(`TAG_DIV);
  localparam logic [TW-1:0] TP    = TW'(`TAG_P);
  localparam logic [TW-1:0] TIMG  = TW'(`TAG_IMG);
  localparam logic [TW-1:0] TA    = TW'(`TAG_A);

  typedef struct { int id; int parent; int depth; int tag; int cyc; } node_t;
  typedef struct { int id; int typ; int val; int cyc; } attr_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  dom_tree_builder_if #(.NODE_ID_BITS(6), .DEPTH_BITS(4)) ifa ();
  dom_tree_builder_if #(.NODE_ID_BITS(3), .DEPTH_BITS(4)) ifb ();

  dom_tree_builder #(.MAX_DEPTH(8), .DEPTH_BITS(4), .NODE_ID_BITS(6)) dut_a (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (ifa.slave)
  );

  dom_tree_builder #(.MAX_DEPTH(8), .DEPTH_BITS(4), .NODE_ID_BITS(3)) dut_b (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (ifb.slave)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rise_cyc = 0;

  node_t node_q[$];
  int    close_q[$];
  attr_t attr_q[$];
  int    b_node_q[$];
  int    b_attr_cnt = 0;

  // Reference model state
  int    m_sid[$];
  int    m_stag[$];
  int    m_next;
  bit    m_ovf, m_udf, m_mis, m_full, m_done;
  node_t exp_node_q[$];
  int    exp_close_q[$];
  attr_t exp_attr_q[$];

  // Output monitor: logs every pulse with the cycle it was seen in.
  initial forever begin
    @(posedge clock);
    #1;
    cyc++;
    if (ifa.node_valid === 1'b1)
      node_q.push_back('{int'(ifa.node_id), int'(ifa.node_parent_id), int'(ifa.node_depth),
                         int'(ifa.node_tag), cyc});
    if (ifa.close_valid === 1'b1) close_q.push_back(int'(ifa.close_id));
    if (ifa.attr_valid === 1'b1)
      attr_q.push_back('{int'(ifa.attr_node_id), int'(ifa.attr_type), int'(ifa.attr_value), cyc});
    if (ifb.node_valid === 1'b1) b_node_q.push_back(int'(ifb.node_id));
    if (ifb.attr_valid === 1'b1) b_attr_cnt++;
  end

  task automatic set_in(input logic done, input logic [TW-1:0] tag, input logic closing,
                        input logic ha, input logic [ATW-1:0] at, input logic [AVW-1:0] av);
    ifa.element_done = done; ifa.element_tag = tag; ifa.is_closing_tag = closing;
    ifa.has_attribute = ha; ifa.attribute_type = at; ifa.attribute_value = av;
    ifb.element_done = done; ifb.element_tag = tag; ifb.is_closing_tag = closing;
    ifb.has_attribute = ha; ifb.attribute_type = at; ifb.attribute_value = av;
  endtask

  // with_attr: 0 none, 1 attribute rises one cycle before element_done, 2 simultaneous.
  task automatic send(input logic [TW-1:0] tag, input logic closing, input int with_attr,
                      input logic [ATW-1:0] at, input logic [AVW-1:0] av, input int hold);
    @(negedge clock);
    set_in(1'b0, tag, closing, with_attr == 1, at, av);
    @(negedge clock);
    rise_cyc = cyc + 1;
    set_in(1'b1, tag, closing, with_attr != 0, at, av);
    repeat (hold) @(negedge clock);
    set_in(1'b0, tag, closing, 1'b0, at, av);
    repeat (3) @(negedge clock);
  endtask

  task automatic open_tag(input logic [TW-1:0] tag);
    send(tag, 1'b0, 0, '0, '0, 1);
  endtask

  task automatic close_tag(input logic [TW-1:0] tag);
    send(tag, 1'b1, 0, '0, '0, 1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    set_in(1'b0, '0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    node_q.delete(); close_q.delete(); attr_q.delete(); b_node_q.delete();
    b_attr_cnt = 0;
  endtask

  task automatic model_attr(input int at, input int av);
    if (m_next != 0) exp_attr_q.push_back('{m_next, at, av, 0});
  endtask

  task automatic model_elem(input int tag, input bit closing);
    int pid, ptag;
    if (!closing) begin
      if (m_next == 0) m_full = 1;
      else if (m_sid.size() == 8) m_ovf = 1;
      else begin
        exp_node_q.push_back('{m_next, (m_sid.size() == 0) ? 0 : m_sid[$], m_sid.size(), tag, 0});
        if (tag != `TAG_IMG) begin
          m_sid.push_back(m_next);
          m_stag.push_back(tag);
        end
        m_next = (m_next + 1) % 64;
      end
    end else if (m_sid.size() == 0) begin
      m_udf = 1;
    end else begin
      pid = m_sid.pop_back();
      ptag = m_stag.pop_back();
      exp_close_q.push_back(pid);
      if (ptag != tag) m_mis = 1;
      if (m_sid.size() == 0 && ptag == `TAG_BODY) m_done = 1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_in(1'b0, '0, 1'b0, 1'b0, '0, '0);
    #12;
    total++;
    if ({ifa.node_valid, ifa.close_valid, ifa.attr_valid} !== 3'b000) begin
      bad++;
      $display("FAIL reset_pulses got=%b want=000", {ifa.node_valid, ifa.close_valid, ifa.attr_valid});
    end
    total++;
    if ({ifa.node_id, ifa.node_parent_id, ifa.node_tag, ifa.node_depth, ifa.close_id,
         ifa.attr_node_id, ifa.attr_type, ifa.attr_value} !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h want=0", {ifa.node_id, ifa.node_parent_id, ifa.node_tag,
               ifa.node_depth, ifa.close_id, ifa.attr_node_id, ifa.attr_type, ifa.attr_value});
    end
    total++;
    if ({ifa.doc_done, ifa.err_overflow, ifa.err_underflow, ifa.err_mismatch, ifa.err_node_full,
         ifb.err_node_full} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000", {ifa.doc_done, ifa.err_overflow,
               ifa.err_underflow, ifa.err_mismatch, ifa.err_node_full, ifb.err_node_full});
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_nested();
    int e_par[3] = '{0, 1, 2};
    int e_close[3] = '{3, 2, 1};
    int rc0;
    do_reset();
    open_tag(TBODY); rc0 = rise_cyc;
    open_tag(TDIV); open_tag(TP);
    close_tag(TP); close_tag(TDIV); close_tag(TBODY);
    total++;
    if (node_q.size() != 3) begin
      bad++; $display("FAIL nested_node_count got=%0d want=3", node_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (node_q[i].id != i + 1 || node_q[i].parent != e_par[i] || node_q[i].depth != i) begin
          bad++;
          $display("FAIL nested_node%0d got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", i, node_q[i].id,
                   node_q[i].parent, node_q[i].depth, i + 1, e_par[i], i);
        end
      end
      total++;
      if (node_q[0].cyc != rc0 + 1) begin
        bad++; $display("FAIL nested_latency got=%0d want=%0d", node_q[0].cyc, rc0 + 1);
      end
    end
    total++;
    if (close_q.size() != 3) begin
      bad++; $display("FAIL nested_close_count got=%0d want=3", close_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (close_q[i] != e_close[i]) begin
          bad++; $display("FAIL nested_close%0d got=%0d want=%0d", i, close_q[i], e_close[i]);
        end
      end
    end
    total++;
    if (ifa.doc_done !== 1'b1) begin
      bad++; $display("FAIL nested_doc_done got=%b want=1", ifa.doc_done);
    end
    total++;
    if ({ifa.err_overflow, ifa.err_underflow, ifa.err_mismatch, ifa.err_node_full} !== 4'b0) begin
      bad++; $display("FAIL nested_errors got=%b want=0000", {ifa.err_overflow, ifa.err_underflow,
                      ifa.err_mismatch, ifa.err_node_full});
    end
  endtask

  task automatic test_attr();
    do_reset();
    send(TA, 1'b0, 1, ATW'(3), AVW'(8'hA5), 3);
    total++;
    if (attr_q.size() != 1 || attr_q[0].id != 1 || attr_q[0].typ != 3 || attr_q[0].val != 'hA5) begin
      bad++;
      $display("FAIL attr_record got_count=%0d want=1 rec(id=1,type=3,val=a5)", attr_q.size());
    end
    total++;
    if (node_q.size() != 1 || node_q[0].id != 1) begin
      bad++; $display("FAIL attr_single_node got_count=%0d want=1 with id 1", node_q.size());
    end
    total++;
    if (attr_q.size() != 1 || node_q.size() != 1 || attr_q[0].cyc >= node_q[0].cyc) begin
      bad++; $display("FAIL attr_order got=attr not strictly before node want=attr first");
    end
  endtask

  task automatic test_void();
    do_reset();
    open_tag(TDIV); open_tag(TIMG); open_tag(TP);
    total++;
    if (node_q.size() != 3) begin
      bad++; $display("FAIL void_count got=%0d want=3", node_q.size());
    end else begin
      total++;
      if (node_q[1].id != 2 || node_q[1].parent != 1 || node_q[1].tag != `TAG_IMG) begin
        bad++; $display("FAIL void_img got=(%0d,%0d,t%0d) want=(2,1,t%0d)", node_q[1].id,
                        node_q[1].parent, node_q[1].tag, `TAG_IMG);
      end
      total++;
      if (node_q[2].id != 3 || node_q[2].parent != 1 || node_q[2].depth != 1) begin
        bad++; $display("FAIL void_p got=(%0d,%0d,%0d) want=(3,1,1)", node_q[2].id,
                        node_q[2].parent, node_q[2].depth);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    repeat (9) open_tag(TDIV);
    total++;
    if (node_q.size() != 8 || ifa.err_overflow !== 1'b1) begin
      bad++; $display("FAIL overflow got_nodes=%0d err=%b want_nodes=8 err=1", node_q.size(),
                      ifa.err_overflow);
    end
    close_tag(TDIV);
    total++;
    if (close_q.size() != 1 || close_q[0] != 8) begin
      bad++; $display("FAIL overflow_pop got_count=%0d want one close of id 8", close_q.size());
    end
    open_tag(TP);
    total++;
    if (node_q.size() != 9 || node_q[8].id != 9 || node_q[8].parent != 7 || node_q[8].depth != 7)
    begin
      bad++; $display("FAIL overflow_next_id got_count=%0d want node (9,7,7)", node_q.size());
    end
  endtask

  task automatic test_underflow();
    do_reset();
    close_tag(TDIV);
    total++;
    if (close_q.size() != 0 || ifa.err_underflow !== 1'b1) begin
      bad++; $display("FAIL underflow got_closes=%0d err=%b want=0 err=1", close_q.size(),
                      ifa.err_underflow);
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    open_tag(TDIV); close_tag(TP);
    total++;
    if (close_q.size() != 1 || close_q[0] != 1 || ifa.err_mismatch !== 1'b1) begin
      bad++; $display("FAIL mismatch got_closes=%0d err=%b want one close id 1 err=1",
                      close_q.size(), ifa.err_mismatch);
    end
    open_tag(TA);
    total++;
    if (node_q.size() != 2 || node_q[1].id != 2 || node_q[1].parent != 0 || node_q[1].depth != 0)
    begin
      bad++; $display("FAIL mismatch_recover got_count=%0d want node (2,0,0)", node_q.size());
    end
  endtask

  task automatic test_id_exhaust();
    do_reset();
    send(TIMG, 1'b0, 2, ATW'(1), AVW'(9), 1);
    total++;
    if (b_attr_cnt != 1) begin
      bad++; $display("FAIL exhaust_early_attr got=%0d want=1", b_attr_cnt);
    end
    repeat (6) open_tag(TIMG);
    total++;
    if (b_node_q.size() != 7 || b_node_q[6] != 7 || ifb.err_node_full !== 1'b0) begin
      bad++; $display("FAIL exhaust_ids got_count=%0d full=%b want=7 full=0", b_node_q.size(),
                      ifb.err_node_full);
    end
    open_tag(TIMG);
    total++;
    if (b_node_q.size() != 7 || ifb.err_node_full !== 1'b1) begin
      bad++; $display("FAIL exhaust_full got_count=%0d full=%b want=7 full=1", b_node_q.size(),
                      ifb.err_node_full);
    end
    send(TDIV, 1'b0, 2, ATW'(2), AVW'(7), 1);
    total++;
    if (b_attr_cnt != 1 || b_node_q.size() != 7) begin
      bad++; $display("FAIL exhaust_attr_drop got_attrs=%0d nodes=%0d want=1,7", b_attr_cnt,
                      b_node_q.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    open_tag(TDIV); close_tag(TP); close_tag(TP);
    node_q.delete();
    @(negedge clock);
    set_in(1'b1, TDIV, 1'b0, 1'b0, '0, '0);
    @(posedge clock);
    @(negedge clock);
    total++;
    if ({ifa.err_mismatch, ifa.err_underflow} !== 2'b11) begin
      bad++; $display("FAIL async_pre_state got=%b want=11", {ifa.err_mismatch, ifa.err_underflow});
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({ifa.doc_done, ifa.err_overflow, ifa.err_underflow, ifa.err_mismatch, ifa.err_node_full,
         ifa.node_valid, ifa.close_valid, ifa.attr_valid} !== 8'b0) begin
      bad++; $display("FAIL async_flags got=%b want=0", {ifa.doc_done, ifa.err_overflow,
                      ifa.err_underflow, ifa.err_mismatch, ifa.err_node_full, ifa.node_valid,
                      ifa.close_valid, ifa.attr_valid});
    end
    total++;
    if ({ifa.node_id, ifa.close_id} !== '0) begin
      bad++; $display("FAIL async_data got=%h want=0", {ifa.node_id, ifa.close_id});
    end
    set_in(1'b0, '0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    total++;
    if (node_q.size() != 0) begin
      bad++; $display("FAIL async_no_node got=%0d want=0", node_q.size());
    end
    open_tag(TBODY);
    total++;
    if (node_q.size() != 1 || node_q[0].id != 1 || node_q[0].parent != 0 || node_q[0].depth != 0)
    begin
      bad++; $display("FAIL async_restart got_count=%0d want node (1,0,0)", node_q.size());
    end
  endtask

  task automatic test_random();
    logic [TW-1:0] tagset[5] = '{TBODY, TDIV, TP, TIMG, TA};
    logic [TW-1:0] tag;
    logic [ATW-1:0] at;
    logic [AVW-1:0] av;
    bit closing;
    int wa;
    do_reset();
    m_sid.delete(); m_stag.delete(); m_next = 1;
    m_ovf = 0; m_udf = 0; m_mis = 0; m_full = 0; m_done = 0;
    exp_node_q.delete(); exp_close_q.delete(); exp_attr_q.delete();
    for (int n = 0; n < 120; n++) begin
      closing = ($urandom_range(0, 99) < 40);
      tag = tagset[$urandom_range(0, 4)];
      if (closing && m_stag.size() > 0 && $urandom_range(0, 3) != 0) tag = TW'(m_stag[$]);
      wa = $urandom_range(0, 2);
      at = ATW'($urandom);
      av = AVW'($urandom);
      if (wa != 0 && !closing) model_attr(int'(at), int'(av));
      model_elem(int'(tag), closing);
      send(tag, closing, wa, at, av, $urandom_range(1, 3));
    end
    total++;
    if (node_q.size() != exp_node_q.size()) begin
      bad++; $display("FAIL rand_node_count got=%0d want=%0d", node_q.size(), exp_node_q.size());
    end else begin
      foreach (exp_node_q[i]) begin
        total++;
        if (node_q[i].id != exp_node_q[i].id || node_q[i].parent != exp_node_q[i].parent ||
            node_q[i].depth != exp_node_q[i].depth || node_q[i].tag != exp_node_q[i].tag) begin
          bad++;
          $display("FAIL rand_node%0d got=(%0d,%0d,%0d,t%0d) want=(%0d,%0d,%0d,t%0d)", i,
                   node_q[i].id, node_q[i].parent, node_q[i].depth, node_q[i].tag,
                   exp_node_q[i].id, exp_node_q[i].parent, exp_node_q[i].depth, exp_node_q[i].tag);
        end
      end
    end
    total++;
    if (close_q != exp_close_q) begin
      bad++; $display("FAIL rand_closes got_count=%0d want_count=%0d (or ids differ)",
                      close_q.size(), exp_close_q.size());
    end
    total++;
    if (attr_q.size() != exp_attr_q.size()) begin
      bad++; $display("FAIL rand_attr_count got=%0d want=%0d", attr_q.size(), exp_attr_q.size());
    end else begin
      foreach (exp_attr_q[i]) begin
        total++;
        if (attr_q[i].id != exp_attr_q[i].id || attr_q[i].typ != exp_attr_q[i].typ ||
            attr_q[i].val != exp_attr_q[i].val) begin
          bad++;
          $display("FAIL rand_attr%0d got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", i, attr_q[i].id,
                   attr_q[i].typ, attr_q[i].val, exp_attr_q[i].id, exp_attr_q[i].typ,
                   exp_attr_q[i].val);
        end
      end
    end
    total++;
    if ({ifa.doc_done, ifa.err_overflow, ifa.err_underflow, ifa.err_mismatch, ifa.err_node_full}
        !== {m_done, m_ovf, m_udf, m_mis, m_full}) begin
      bad++; $display("FAIL rand_flags got=%b want=%b", {ifa.doc_done, ifa.err_overflow,
                      ifa.err_underflow, ifa.err_mismatch, ifa.err_node_full},
                      {m_done, m_ovf, m_udf, m_mis, m_full});
    end
  endtask

  initial begin
    test_reset();
    test_nested();
    test_attr();
    test_void();
    test_overflow();
    test_underflow();
    test_mismatch();
    test_id_exhaust();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
